comm_collect: RTL and testbench
===============================

Name: comm_collect

Overview:
Reverse-direction partner of the pipelined commutator. It gathers sparse single-cycle requests from nSRC endpoints, each carrying a wD-bit word, and funnels them onto one output channel. Each emitted word is tagged with the index of its source endpoint, so the far side can decode the origin the same way the commutator decodes a destination address. Every source has one holding slot, and a round-robin arbiter drains at most one word per cycle.

Parameters:
nSRC, 32, number of source endpoints (any value ≥2, not necessarily a power of two)
wD, 38, payload width per word
wA, $clog2(nSRC), width of the source-index tag (derived; not overridden)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_in  in  nSRC  per-source request strobe; bit i is valid for exactly the cycle it is high
data_in  in  nSRC*wD  flattened payloads; source i occupies bits [(i+1)*wD-1 : i*wD]
req_out  out  1  registered output strobe; high for one cycle per emitted word
data_out  out  wD  registered payload of the emitted word
addr_out  out  wA  registered source index of the emitted word
overflow  out  nSRC  sticky per-source drop flag

Behaviour:
- One clock, clk. Reset is synchronous and active-high: every register below clears on a clk edge with reset=1.
- Reset values: req_out=0, data_out=0, addr_out=0, overflow=0, all slot valid bits=0, slot data=0, round-robin pointer ptr=0.
- Reset asserted mid-operation discards all pending slot contents without emitting them. req_in sampled on a reset edge is ignored.
- Slot i holds one register pair: valid_i and dat_i (wD bits).
- Capture rules on each edge, with reset=0:
  - req_in[i]=1 and valid_i=0: load dat_i, set valid_i=1.
  - req_in[i]=1, valid_i=1, and slot i granted this cycle: reload dat_i with the new word; valid_i stays 1. This is not an overflow.
  - req_in[i]=1, valid_i=1, and slot i not granted: drop the new word, keep dat_i, set overflow[i]=1.
  - req_in[i]=0 and slot i granted: clear valid_i.
- overflow[i] clears only on reset.
- Arbiter (combinational on the registered valid bits):
  - Search starts at ptr and wraps through indices ptr, ptr+1, …, nSRC-1, 0, …, ptr-1.
  - The first set valid bit wins; grant index g.
- Output register on each edge:
  - If any slot is valid: req_out=1, data_out=dat_g, addr_out=g, ptr←(g+1) mod nSRC. The wrap must be correct for non-power-of-2 nSRC.
  - If no slot is valid: req_out=0, and data_out, addr_out, and ptr hold their values.
- Latency: a request sampled at edge t is in its slot after edge t. If it wins immediately, it appears on req_out after edge t+1, i.e. 2 cycles from req_in high to req_out high.
- Worst-case wait: nSRC-1 further cycles, since every other slot is served once before a given slot.
- Throughput: one word per cycle and no back-pressure. The downstream side must always accept req_out.
- Ordering: words from the same source are emitted in arrival order. Any word that would break this ordering is dropped and flagged instead.

Decomposition:
- Package comm_pkg holds the shared localparams and helper functions: the wA computation and the slice-index function for the flattened data bus. The commutator and this block both use the package.
- One sub-module, comm_rr_arbiter, with parameter N. Inputs: valid[N], ptr. Outputs: grant_valid, grant_idx. It is purely combinational, built as a double-width priority encoder over the rotated vector.
- Slots, pointer, and output registers stay in comm_collect.

Test Plan:
1. After reset, req_in[5]=1 with word 0x12 for one cycle → two cycles later req_out=1, addr_out=5, data_out=0x12 for exactly one cycle. overflow stays 0.
2. All 32 req_in bits high in one cycle, with data_in word i = i → req_out high for 32 consecutive cycles with addr_out=0,1,…,31 and data_out equal to addr_out, then req_out=0. No overflow.
3. Sources 3 and 7 request every other cycle, data incrementing → outputs alternate between addr 3 and addr 7, each source's data stays in order, overflow=0.
4. Source 9 requests on three consecutive cycles (A, B, C) while sources 0 to 8 are all pending → A is emitted, B is dropped, overflow[9]=1, and C either replaces A on grant or is also dropped, exactly per the capture rules. overflow[9] stays 1 until reset.
5. 16 slots are pending and reset is asserted for one cycle → the next edge shows req_out=0, and no stale word ever appears. A fresh request to source 0 is then emitted first, because ptr=0.
6. Run with nSRC=12 (not a power of two) and source 11 granted → ptr wraps to 0 and the next grant order starts at 0. Run randomized traffic against a scoreboard: every accepted word is emitted exactly once, and drops occur only where overflow is flagged.

Source files
------------

// File: rtl/comm_pkg.sv
// Shared definitions for the commutator / collector pair: default sizes,
// index-width derivation and flattened-bus slice arithmetic.
package comm_pkg;

    localparam int COMM_N_SRC_DEF = 32;
    localparam int COMM_W_D_DEF   = 38;

    // Width of an endpoint index; never narrower than one bit.
    function automatic int comm_addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Lowest bit of endpoint idx on a flattened bus of w-bit words.
    function automatic int comm_slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

    // Modulo-n increment that stays correct when n is not a power of two.
    function automatic int comm_wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/comm_rr_arbiter.sv
// Combinational round-robin arbiter: lowest set bit at or after ptr wins,
// found by priority-encoding a window of the doubled request vector.
module comm_rr_arbiter
    import comm_pkg::*;
#(
    parameter  int N = COMM_N_SRC_DEF,
    localparam int W = comm_addr_w(N)
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic         grant_valid,
    output logic [W-1:0] grant_idx
);

    localparam logic [W:0] N_EXT = N[W:0];

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W-1:0]   off;
    logic [W:0]     sum;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        dbl         = {valid, valid};
        rot         = dbl[ptr +: N];
        grant_valid = 1'b0;
        off         = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                grant_valid = 1'b1;
                off         = W'(i);
            end
        end
        sum       = {1'b0, ptr} + {1'b0, off};
        grant_idx = (sum >= N_EXT) ? W'(sum - N_EXT) : W'(sum);
    end

endmodule

// File: rtl/comm_collect.sv
// Collects sparse per-source words into one-deep slots and drains them
// round-robin onto a single channel tagged with the source index.
module comm_collect
    import comm_pkg::*;
#(
    parameter  int nSRC = COMM_N_SRC_DEF,
    parameter  int wD   = COMM_W_D_DEF,
    localparam int wA   = comm_addr_w(nSRC)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [nSRC-1:0]      req_in,
    input  logic [nSRC*wD-1:0]   data_in,
    output logic                 req_out,
    output logic [wD-1:0]        data_out,
    output logic [wA-1:0]        addr_out,
    output logic [nSRC-1:0]      overflow
);

    logic [nSRC-1:0] valid_q, valid_d;
    logic [wD-1:0]   dat_q [nSRC];
    logic [wD-1:0]   dat_d [nSRC];
    logic [nSRC-1:0] ovf_q, ovf_d;
    logic            req_out_q, req_out_d;
    logic [wD-1:0]   data_out_q, data_out_d;
    logic [wA-1:0]   addr_out_q, addr_out_d;
    logic [wA-1:0]   ptr_q, ptr_d;

    logic            grant_valid;
    logic [wA-1:0]   grant_idx;

    comm_rr_arbiter #(.N(nSRC)) u_arb (
        .valid       (valid_q),
        .ptr         (ptr_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // NOTE: combinational next-state logic uses blocking '=', so later
    // statements see the values computed earlier in the same pass.
    always_comb begin
        valid_d    = valid_q;
        dat_d      = dat_q;
        ovf_d      = ovf_q;
        req_out_d  = grant_valid;
        data_out_d = data_out_q;
        addr_out_d = addr_out_q;
        ptr_d      = ptr_q;

        if (grant_valid) begin
            data_out_d = dat_q[grant_idx];
            addr_out_d = grant_idx;
            ptr_d      = wA'(comm_wrap_inc(int'(grant_idx), nSRC));
        end

        // A slot being drained this cycle may take a new word; otherwise a
        // second word would overtake the first, so it is dropped and flagged.
        for (int i = 0; i < nSRC; i++) begin
            if (req_in[i]) begin
                if (!valid_q[i] || (grant_valid && grant_idx == wA'(i))) begin
                    valid_d[i] = 1'b1;
                    dat_d[i]   = data_in[comm_slice_lo(i, wD) +: wD];
                end else begin
                    ovf_d[i]   = 1'b1;
                end
            end else if (grant_valid && grant_idx == wA'(i)) begin
                valid_d[i] = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking '<=' so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= '0;
            ovf_q      <= '0;
            req_out_q  <= 1'b0;
            data_out_q <= '0;
            addr_out_q <= '0;
            ptr_q      <= '0;
            // NOTE: slot payloads are cleared too, so nothing stale survives reset.
            for (int i = 0; i < nSRC; i++) dat_q[i] <= '0;
        end else begin
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            req_out_q  <= req_out_d;
            data_out_q <= data_out_d;
            addr_out_q <= addr_out_d;
            ptr_q      <= ptr_d;
            for (int i = 0; i < nSRC; i++) dat_q[i] <= dat_d[i];
        end
    end

    assign req_out  = req_out_q;
    assign data_out = data_out_q;
    assign addr_out = addr_out_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_comm_collect.sv
// Bench for comm_collect: a 32-source and a 12-source instance, directed
// scenarios plus random traffic, checked against a slot/queue reference model.
module tb_comm_collect;

    localparam int WD = 38;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [31:0]      req32;
    logic [32*WD-1:0] din32;
    logic             r_out32;
    logic [WD-1:0]    d_out32;
    logic [4:0]       a_out32;
    logic [31:0]      ovf32;

    logic [11:0]      req12;
    logic [12*WD-1:0] din12;
    logic             r_out12;
    logic [WD-1:0]    d_out12;
    logic [3:0]       a_out12;
    logic [11:0]      ovf12;

    comm_collect #(.nSRC(32), .wD(WD)) dut32 (
        .clk(clk), .reset(reset), .req_in(req32), .data_in(din32),
        .req_out(r_out32), .data_out(d_out32), .addr_out(a_out32), .overflow(ovf32)
    );

    comm_collect #(.nSRC(12), .wD(WD)) dut12 (
        .clk(clk), .reset(reset), .req_in(req12), .data_in(din12),
        .req_out(r_out12), .data_out(d_out12), .addr_out(a_out12), .overflow(ovf12)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stimulus applied to whichever instance is selected.
    bit            sel12 = 1'b0;
    int            n_src = 32;
    logic [31:0]   stim_req;
    logic [WD-1:0] stim_w [32];

    // Reference model: one holding place per source, rotating service order.
    bit            m_full [32];
    logic [WD-1:0] m_word [32];
    int            m_ptr;
    bit            m_req;
    logic [WD-1:0] m_data;
    int            m_addr;
    logic [31:0]   m_ovf;
    logic [WD-1:0] sbq [32][$];

    task automatic drive();
        req32 = sel12 ? '0 : stim_req;
        req12 = sel12 ? stim_req[11:0] : '0;
        for (int i = 0; i < 32; i++) din32[i*WD +: WD] = sel12 ? '0 : stim_w[i];
        for (int i = 0; i < 12; i++) din12[i*WD +: WD] = sel12 ? stim_w[i] : '0;
    endtask

    task automatic model_edge();
        int  g;
        bit  any;
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_full[i] = 1'b0;
                m_word[i] = '0;
                sbq[i].delete();
            end
            m_ptr = 0; m_req = 1'b0; m_data = '0; m_addr = 0; m_ovf = '0;
            return;
        end
        any = 1'b0;
        g   = 0;
        for (int k = 0; k < n_src; k++) begin
            int idx;
            idx = (m_ptr + k) % n_src;
            if (!any && m_full[idx]) begin
                any = 1'b1;
                g   = idx;
            end
        end
        m_req = any;
        if (any) begin
            m_data = m_word[g];
            m_addr = g;
            m_ptr  = (g + 1) % n_src;
        end
        for (int i = 0; i < n_src; i++) begin
            if (stim_req[i]) begin
                if (!m_full[i] || (any && g == i)) begin
                    m_full[i] = 1'b1;
                    m_word[i] = stim_w[i];
                    sbq[i].push_back(stim_w[i]);
                end else begin
                    m_ovf[i] = 1'b1;
                end
            end else if (any && g == i) begin
                m_full[i] = 1'b0;
            end
        end
    endtask

    task automatic compare();
        logic [63:0]   oreq, oaddr, odata, oovf;
        logic [WD-1:0] exp_w;
        if (sel12) begin
            oreq = 64'(r_out12); oaddr = 64'(a_out12); odata = 64'(d_out12); oovf = 64'(ovf12);
        end else begin
            oreq = 64'(r_out32); oaddr = 64'(a_out32); odata = 64'(d_out32); oovf = 64'(ovf32);
        end
        check("req_out", oreq, 64'(m_req));
        check("addr_out", oaddr, 64'(m_addr));
        check("data_out", odata, 64'(m_data));
        check("overflow", oovf, 64'(m_ovf));
        if (oreq == 64'd1 && !reset) begin
            if (oaddr < 64'(n_src) && sbq[int'(oaddr)].size() > 0) begin
                exp_w = sbq[int'(oaddr)].pop_front();
                check("sb_order", odata, 64'(exp_w));
            end else begin
                check("sb_unexpected_addr", oaddr, 64'hffff_ffff);
            end
        end
    endtask

    task automatic cycle();
        drive();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic idle(input int n);
        stim_req = '0;
        for (int c = 0; c < n; c++) cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic rand_words();
        logic [63:0] r;
        for (int i = 0; i < 32; i++) begin
            r = {$urandom, $urandom};
            stim_w[i] = r[WD-1:0];
        end
    endtask

    task automatic check_drained(input string tag);
        int left;
        left = 0;
        for (int i = 0; i < 32; i++) left += sbq[i].size();
        check(tag, 64'(left), 64'd0);
    endtask

    initial begin
        int pulses;
        int exp_addr;
        stim_req = '0;
        for (int i = 0; i < 32; i++) stim_w[i] = '0;

        // Reset state
        do_reset();
        do_reset();
        check("rst_req", 64'(r_out32), 64'd0);
        check("rst_ovf", 64'(ovf32), 64'd0);

        // 1: single request, two-cycle latency, one-cycle pulse
        stim_req = 32'h1 << 5;
        stim_w[5] = 38'h12;
        cycle();
        check("t1_latency", 64'(r_out32), 64'd0);
        idle(1);
        check("t1_req", 64'(r_out32), 64'd1);
        check("t1_addr", 64'(a_out32), 64'd5);
        check("t1_data", 64'(d_out32), 64'h12);
        idle(1);
        check("t1_pulse_end", 64'(r_out32), 64'd0);
        check("t1_ovf", 64'(ovf32), 64'd0);

        // 2: every source at once, drained in index order
        do_reset();
        for (int i = 0; i < 32; i++) stim_w[i] = WD'(i);
        stim_req = '1;
        cycle();
        stim_req = '0;
        pulses = 0;
        exp_addr = 0;
        for (int c = 0; c < 34; c++) begin
            cycle();
            if (r_out32) begin
                check("t2_addr", 64'(a_out32), 64'(exp_addr));
                check("t2_data", 64'(d_out32), 64'(exp_addr));
                exp_addr++;
                pulses++;
            end
        end
        check("t2_pulses", 64'(pulses), 64'd32);
        check("t2_idle", 64'(r_out32), 64'd0);
        check("t2_ovf", 64'(ovf32), 64'd0);

        // 3: two sources every other cycle
        for (int c = 0; c < 20; c++) begin
            stim_req = (c % 2 == 0) ? ((32'h1 << 3) | (32'h1 << 7)) : 32'h0;
            stim_w[3] = WD'(100 + c);
            stim_w[7] = WD'(200 + c);
            cycle();
        end
        idle(4);
        check("t3_ovf", 64'(ovf32), 64'd0);

        // 4: source 9 bursts A, B, C behind pending sources 0..8
        do_reset();
        rand_words();
        stim_req = 32'h1ff;
        cycle();
        for (int k = 0; k < 3; k++) begin
            stim_req = 32'h1 << 9;
            stim_w[9] = WD'(38'h0A0 + k);
            cycle();
        end
        check("t4_ovf9", 64'(ovf32[9]), 64'd1);
        stim_req = '0;
        for (int c = 0; c < 15; c++) begin
            cycle();
            if (r_out32 && a_out32 == 5'd9) check("t4_word_a", 64'(d_out32), 64'h0A0);
        end
        check("t4_ovf9_sticky", 64'(ovf32[9]), 64'd1);
        check("t4_ovf_others", 64'(ovf32 & ~(32'h1 << 9)), 64'd0);

        // 5: reset with 16 slots pending
        stim_req = 32'h0000ffff;
        rand_words();
        cycle();
        idle(1);
        reset = 1'b1;
        stim_req = 32'hffffffff;
        cycle();
        reset = 1'b0;
        check("t5_after_reset", 64'(r_out32), 64'd0);
        for (int c = 0; c < 3; c++) begin
            idle(1);
            check("t5_no_stale", 64'(r_out32), 64'd0);
        end
        stim_req = 32'h1 | (32'h1 << 20);
        cycle();
        idle(1);
        check("t5_first_req", 64'(r_out32), 64'd1);
        check("t5_first_addr", 64'(a_out32), 64'd0);
        idle(3);

        // Random traffic, 32 sources
        for (int c = 0; c < 300; c++) begin
            rand_words();
            for (int i = 0; i < 32; i++) stim_req[i] = ($urandom_range(15) == 0);
            cycle();
        end
        idle(40);
        check_drained("sb_drained32");

        // 6: twelve sources, pointer wrap from 11 to 0
        sel12 = 1'b1;
        n_src = 12;
        stim_req = '0;
        do_reset();
        stim_req = 32'h1 << 10;
        cycle();
        stim_req = 32'h1 << 11;
        cycle();
        check("t6_addr10", 64'(a_out12), 64'd10);
        idle(1);
        check("t6_addr11", 64'(a_out12), 64'd11);
        stim_req = 32'h1 | (32'h1 << 5) | (32'h1 << 11);
        cycle();
        idle(1);
        check("t6_wrap_first", 64'(a_out12), 64'd0);
        idle(1);
        check("t6_second", 64'(a_out12), 64'd5);
        idle(1);
        check("t6_third", 64'(a_out12), 64'd11);
        idle(2);

        // Random traffic, 12 sources
        for (int c = 0; c < 400; c++) begin
            rand_words();
            stim_req = '0;
            for (int i = 0; i < 12; i++) stim_req[i] = ($urandom_range(7) == 0);
            cycle();
        end
        idle(30);
        check_drained("sb_drained12");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
